// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scan_decoder
// Purpose : Recovers hex nibbles from a multiplexed active-low 7-seg bus.
// Rev     : 1.0  initial release
// ============================================================================
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [0:6]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    glyph_err,
  output logic [NUM_DIGITS-1:0]   err_digit
);

  localparam int                  CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [0:6]              s_seg_q, s_seg_d;
  logic [NUM_DIGITS-1:0]   s_an_q, s_an_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
  logic                    frame_done_q, frame_done_d;
  logic                    glyph_err_q, glyph_err_d;
  logic [NUM_DIGITS-1:0]   err_digit_q, err_digit_d;

  logic                    chg;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    sel_onehot;
  logic [4:0]              dec;

  // Returns {legal, nibble}; only exact encoder glyphs are legal.
  function automatic logic [4:0] decode(input logic [0:6] p);
    case (p)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001111: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0000100: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b1100000: decode = 5'h1B;
      7'b0110001: decode = 5'h1C;
      7'b1000010: decode = 5'h1D;
      7'b0110000: decode = 5'h1E;
      7'b0111000: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - DIG_ONE)) == '0);
  endfunction

  always_comb begin
    s_seg_d = seg;
    s_an_d  = an;
    // Change is seen on the edge the new pair is registered, so the
    // counter restarts at the same time the pattern enters the input stage.
    chg     = (s_seg_d != s_seg_q) || (s_an_d != s_an_q);
    if (chg)                 cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + CNT_ONE;

    sel        = ~s_an_q;
    sel_onehot = is_onehot(sel);
    dec        = decode(s_seg_q);

    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_onehot) state_d = SETTLE;
      end
      SETTLE: begin
        if (!sel_onehot) begin
          state_d = IDLE;
        end else if (!chg && (cnt_d == CNT_MAX)) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (chg) state_d = is_onehot(~s_an_d) ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    frame_done_d  = &digit_valid_q;
    digit_valid_d = frame_done_d ? '0 : digit_valid_q;
    value_d       = value_q;
    glyph_err_d   = glyph_err_q;
    err_digit_d   = err_digit_q;
    if (capture) begin
      if (dec[4]) begin
        digit_valid_d = digit_valid_d | sel;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) value_d[4*i +: 4] = dec[3:0];
        end
      end else begin
        glyph_err_d = 1'b1;
        err_digit_d = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      s_seg_q       <= 7'h7F;
      s_an_q        <= '1;
      cnt_q         <= '0;
      value_q       <= '0;
      digit_valid_q <= '0;
      frame_done_q  <= 1'b0;
      glyph_err_q   <= 1'b0;
      err_digit_q   <= '0;
    end else begin
      state_q       <= state_d;
      s_seg_q       <= s_seg_d;
      s_an_q        <= s_an_d;
      cnt_q         <= cnt_d;
      value_q       <= value_d;
      digit_valid_q <= digit_valid_d;
      frame_done_q  <= frame_done_d;
      glyph_err_q   <= glyph_err_d;
      err_digit_q   <= err_digit_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = digit_valid_q;
  assign frame_done  = frame_done_q;
  assign glyph_err   = glyph_err_q;
  assign err_digit   = err_digit_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_seg_scan_decoder
// Purpose : Scoreboard bench for seven_seg_scan_decoder (4 digits, 4 cycles).
// Rev     : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        glyph_err;
  logic [3:0]  err_digit;

  seven_seg_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .glyph_err   (glyph_err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int          q_cyc[$];
  string       q_nm[$];
  logic [25:0] q_exp[$];

  logic [15:0] exp_value = '0;
  logic [3:0]  exp_dv    = '0;
  logic        exp_fd    = 1'b0;
  logic        exp_ge    = 1'b0;
  logic [3:0]  exp_ed    = '0;

  task automatic push(input int off, input string nm);
    q_cyc.push_back(cyc + off);
    q_nm.push_back(nm);
    q_exp.push_back({exp_value, exp_dv, exp_fd, exp_ge, exp_ed});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] a);
    seg = s;
    an  = a;
  endtask

  // Monitor: outputs sampled on the falling edge, matched by due cycle.
  always @(negedge clk) begin : mon
    int          c;
    string       nm;
    logic [25:0] e;
    logic [25:0] act;
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      c   = q_cyc.pop_front();
      nm  = q_nm.pop_front();
      e   = q_exp.pop_front();
      act = {value, digit_valid, frame_done, glyph_err, err_digit};
      checks++;
      if (c != cyc || act !== e) begin
        errors++;
        $display("FAIL %s cyc=%0d due=%0d: got value=%h dv=%b fd=%b ge=%b ed=%b, want value=%h dv=%b fd=%b ge=%b ed=%b",
                 nm, cyc, c, act[25:10], act[9:6], act[5], act[4], act[3:0],
                 e[25:10], e[9:6], e[5], e[4], e[3:0]);
      end
    end
  end

  logic [6:0] scan_seg [4] = '{7'b1001111, 7'b0010010, 7'b1000010, 7'b0111000};
  logic [3:0] scan_nib [4] = '{4'h1, 4'h2, 4'hD, 4'hF};

  initial begin
    rst_n = 1'b0;
    seg   = 7'h7F;
    an    = 4'hF;
    tick(2);
    push(0, "reset");
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Test 1: digit 0 shows 3
    drive(7'b0000110, 4'b1110);
    push(4, "t1_pre");
    exp_value = 16'h0003;
    exp_dv    = 4'b0001;
    push(5, "t1_cap");
    tick(6);

    // Test 2: full scan 1,2,D,F
    for (int i = 0; i < 4; i++) begin
      drive(scan_seg[i], ~(4'b0001 << i));
      push(4, "t2_pre");
      exp_value[4*i +: 4] = scan_nib[i];
      exp_dv[i]           = 1'b1;
      push(5, "t2_cap");
      if (i == 3) begin
        exp_dv = 4'b0000;
        exp_fd = 1'b1;
        push(6, "t2_frame_done");
        exp_fd = 1'b0;
        push(7, "t2_frame_clear");
      end
      tick(8);
    end

    // Test 3: pattern toggling faster than the stable window
    push(17, "t3_nocap");
    for (int k = 0; k < 5; k++) begin
      drive((k % 2 == 1) ? 7'b0000100 : 7'b0000000, 4'b1110);
      tick(3);
    end
    drive(7'h7F, 4'hF);
    tick(3);

    // Test 4: two digits enabled at once
    drive(7'b0000000, 4'b1100);
    push(10, "t4_ghost");
    tick(11);

    // Test 5: illegal glyph on digit 2, then a legal 7
    drive(7'b1111110, 4'b1011);
    push(4, "t5_pre");
    exp_ge = 1'b1;
    exp_ed = 4'b0100;
    push(5, "t5_illegal");
    tick(6);
    drive(7'b0001111, 4'b1011);
    push(4, "t5_pre7");
    exp_value[11:8] = 4'h7;
    exp_dv          = 4'b0100;
    push(5, "t5_legal7");
    tick(6);

    // All segments off is illegal too
    drive(7'b1111111, 4'b1110);
    push(4, "alloff_pre");
    exp_ed = 4'b0001;
    push(5, "alloff_err");
    tick(6);

    // Test 6: reset while the counter sits at 3
    drive(7'b1001100, 4'b1101);
    tick(4);
    rst_n     = 1'b0;
    exp_value = '0;
    exp_dv    = '0;
    exp_fd    = 1'b0;
    exp_ge    = 1'b0;
    exp_ed    = '0;
    push(0, "t6_async_rst");
    tick(2);
    rst_n = 1'b1;
    push(4, "t6_pre");
    exp_value = 16'h0040;
    exp_dv    = 4'b0010;
    push(5, "t6_cap");
    tick(8);

    if (q_cyc.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q_cyc.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
